// File: rtl/master_control_if.sv
// Handshake bus between the master controller and the slave chip.
//   request  : master -> slave, transfer request
//   data_out : master -> slave, {even parity, payload[1:0]}
//   valid    : master -> slave, data_out strobe
//   ack      : slave -> master, acknowledge (asynchronous to the master clock)
interface master_control_if;
    logic       request;
    logic [2:0] data_out;
    logic       valid;
    logic       ack;

    modport master (
        output request,
        output data_out,
        output valid,
        input  ack
    );

    modport slave (
        input  request,
        input  data_out,
        input  valid,
        output ack
    );
endinterface

// File: rtl/master_control.sv
// Master-side transfer controller: on a send pulse it latches a 2-bit payload
// (plus even parity), raises request, waits for the slave's ack, holds the data
// stable for SETUP_CYCLES, strobes valid for VALID_CYCLES and then flags
// all_done. An ack also lights a fixed-length notice LED.
//
// Ports:
//   clk         : clock, rising edge
//   rst_n       : synchronous active-low reset
//   top_state   : system mode; block is active only in mode 2'b01
//   send        : single-cycle transfer request pulse
//   data_sel    : payload, sampled on an accepted send
//   bus         : master side of master_control_if (request/data_out/valid/ack)
//   notice      : ack-received LED, high NOTICE_CYCLES cycles
//   all_done    : sticky transfer-complete flag
//   timeout_err : sticky ack-timeout flag
//
// Optional feature: define MASTER_ACK_TIMEOUT_EN to abandon a transfer after
// TIMEOUT_CYCLES cycles without ack. Undefined, the wait is unbounded and
// timeout_err is tied low.
module master_control #(
    parameter int unsigned NOTICE_CYCLES  = 100_000_000,
    parameter int unsigned SETUP_CYCLES   = 4,
    parameter int unsigned VALID_CYCLES   = 4,
    parameter int unsigned TIMEOUT_CYCLES = 200_000_000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       top_state,
    input  logic             send,
    input  logic [1:0]       data_sel,
    master_control_if.master bus,
    output logic             notice,
    output logic             all_done,
    output logic             timeout_err
);

    // One counter width covers every parameter.
    localparam int unsigned MAX_SV  = (SETUP_CYCLES > VALID_CYCLES) ? SETUP_CYCLES : VALID_CYCLES;
    localparam int unsigned MAX_NT  = (NOTICE_CYCLES > TIMEOUT_CYCLES) ? NOTICE_CYCLES : TIMEOUT_CYCLES;
    localparam int unsigned MAX_ALL = (MAX_SV > MAX_NT) ? MAX_SV : MAX_NT;
    localparam int unsigned CNT_W   = $clog2(MAX_ALL + 2);
    localparam int unsigned NOTICE_LOAD = (NOTICE_CYCLES > 0) ? NOTICE_CYCLES - 1 : 0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_ACK,
        S_SETUP,
        S_SEND,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic               request_q, request_d;
    logic               valid_q, valid_d;
    logic [2:0]         data_q, data_d;
    logic               all_done_q, all_done_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ack_meta, ack_sync;
    logic               notice_q;
    logic [CNT_W-1:0]   notice_cnt_q;
    logic               active_c;
    logic               accept_c;
    logic               notice_start_c;
`ifdef MASTER_ACK_TIMEOUT_EN
    logic [CNT_W-1:0]   tmo_cnt_q, tmo_cnt_d;
    logic               terr_q, terr_d;
`endif

    assign active_c = (top_state == 2'b01);

    assign bus.request  = request_q;
    assign bus.valid    = valid_q;
    assign bus.data_out = data_q;
    assign notice       = notice_q;
    assign all_done     = all_done_q;
`ifdef MASTER_ACK_TIMEOUT_EN
    assign timeout_err  = terr_q;
`else
    assign timeout_err  = 1'b0;
`endif

    // Two-flop ack synchronizer; leaving the active mode clears it as well.
    always_ff @(posedge clk) begin
        if (!rst_n || !active_c) begin
            ack_meta <= 1'b0;
            ack_sync <= 1'b0;
        end else begin
            ack_meta <= bus.ack;
            ack_sync <= ack_meta;
        end
    end

    // FSM and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n || !active_c) begin
            state_q    <= S_IDLE;
            request_q  <= 1'b0;
            valid_q    <= 1'b0;
            data_q     <= '0;
            all_done_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            request_q  <= request_d;
            valid_q    <= valid_d;
            data_q     <= data_d;
            all_done_q <= all_done_d;
            cnt_q      <= cnt_d;
        end
    end

`ifdef MASTER_ACK_TIMEOUT_EN
    // Ack-wait counter and sticky timeout flag.
    always_ff @(posedge clk) begin
        if (!rst_n || !active_c) begin
            tmo_cnt_q <= '0;
            terr_q    <= 1'b0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
            terr_q    <= terr_d;
        end
    end
`endif

    // Next-state and next-output logic. A phase count of zero behaves as one.
    always_comb begin
        state_d        = state_q;
        request_d      = request_q;
        valid_d        = valid_q;
        data_d         = data_q;
        all_done_d     = all_done_q;
        cnt_d          = cnt_q;
        accept_c       = 1'b0;
        notice_start_c = 1'b0;
`ifdef MASTER_ACK_TIMEOUT_EN
        tmo_cnt_d      = tmo_cnt_q;
        terr_d         = terr_q;
`endif

        case (state_q)
            S_IDLE: begin
                request_d = 1'b0;
                valid_d   = 1'b0;
                if (send) begin
                    accept_c = 1'b1;
                end
            end

            S_WAIT_ACK: begin
                request_d = 1'b1;
                if (ack_sync) begin
                    request_d      = 1'b0;
                    notice_start_c = 1'b1;
                    cnt_d          = CNT_W'(SETUP_CYCLES);
                    state_d        = S_SETUP;
                end
`ifdef MASTER_ACK_TIMEOUT_EN
                else if (tmo_cnt_q <= CNT_W'(1)) begin
                    request_d = 1'b0;
                    terr_d    = 1'b1;
                    tmo_cnt_d = '0;
                    state_d   = S_IDLE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q - CNT_W'(1);
                end
`endif
            end

            S_SETUP: begin
                valid_d = 1'b0;
                if (cnt_q <= CNT_W'(1)) begin
                    valid_d = 1'b1;
                    cnt_d   = CNT_W'(VALID_CYCLES);
                    state_d = S_SEND;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

            S_SEND: begin
                valid_d = 1'b1;
                if (cnt_q <= CNT_W'(1)) begin
                    valid_d    = 1'b0;
                    all_done_d = 1'b1;
                    cnt_d      = '0;
                    state_d    = S_DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

            S_DONE: begin
                all_done_d = 1'b1;
                // A slave still holding ack blocks the next transfer.
                if (send && !ack_sync) begin
                    all_done_d = 1'b0;
                    accept_c   = 1'b1;
                end
            end

            default: begin
                state_d   = S_IDLE;
                request_d = 1'b0;
                valid_d   = 1'b0;
            end
        endcase

        // Accepted send: latch payload with even parity and start the request.
        if (accept_c) begin
            data_d    = {^data_sel, data_sel};
            request_d = 1'b1;
            valid_d   = 1'b0;
            cnt_d     = '0;
            state_d   = S_WAIT_ACK;
`ifdef MASTER_ACK_TIMEOUT_EN
            tmo_cnt_d = CNT_W'(TIMEOUT_CYCLES);
            terr_d    = 1'b0;
`endif
        end
    end

    // Notice LED: fixed-length pulse, runs independently of the FSM and is
    // not retriggered while already lit.
    always_ff @(posedge clk) begin
        if (!rst_n || !active_c) begin
            notice_q     <= 1'b0;
            notice_cnt_q <= '0;
        end else if (notice_q) begin
            if (notice_cnt_q == '0) begin
                notice_q <= 1'b0;
            end else begin
                notice_cnt_q <= notice_cnt_q - CNT_W'(1);
            end
        end else if (notice_start_c && (NOTICE_CYCLES != 0)) begin
            notice_q     <= 1'b1;
            notice_cnt_q <= CNT_W'(NOTICE_LOAD);
        end
    end

endmodule

// File: tb/tb_master_control.sv
// Bench for master_control: a directed vector table, hand-written corner
// sequences, then randomized traffic against a timestamp-based reference.
module tb_master_control;

    localparam int NC = 10;
    localparam int SC = 2;
    localparam int VC = 3;
    localparam int TC = 20;
`ifdef MASTER_ACK_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] top_state;
    logic       send;
    logic [1:0] data_sel;
    logic       notice;
    logic       all_done;
    logic       timeout_err;

    always #5 clk = ~clk;

    master_control_if bus ();

    master_control #(
        .NOTICE_CYCLES (NC),
        .SETUP_CYCLES  (SC),
        .VALID_CYCLES  (VC),
        .TIMEOUT_CYCLES(TC)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .top_state  (top_state),
        .send       (send),
        .data_sel   (data_sel),
        .bus        (bus),
        .notice     (notice),
        .all_done   (all_done),
        .timeout_err(timeout_err)
    );

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic       rst_n;
        logic [1:0] ts;
        logic       send;
        logic [1:0] ds;
        logic       ack;
        logic [7:0] exp;   // {request, data_out[2:0], valid, notice, all_done, timeout_err}
    } vec_t;

    vec_t tbl [22];

    function automatic vec_t mk(input logic r, input logic [1:0] ts, input logic s,
                                input logic [1:0] ds, input logic a, input logic [7:0] e);
        vec_t v;
        v.rst_n = r; v.ts = ts; v.send = s; v.ds = ds; v.ack = a; v.exp = e;
        return v;
    endfunction

    function automatic logic [7:0] outs();
        return {bus.request, bus.data_out, bus.valid, notice, all_done, timeout_err};
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_send(input logic [1:0] ds);
        send = 1'b1;
        data_sel = ds;
        tick();
        send = 1'b0;
    endtask

    // Reference model: tracks when the request started, when the ack was
    // taken and when the notice lit, and derives every output from elapsed
    // edge counts.
    int         m_n, m_req_t, m_ack_t, m_ntc_t;
    bit         m_wait, m_terr, m_s1, m_s2;
    logic [2:0] m_data;

    task automatic model_step(output logic [7:0] e);
        bit a, ntc_on, idle_st, done_st;
        int d;
        m_n++;
        if (!rst_n || top_state != 2'b01) begin
            m_wait = 0; m_terr = 0; m_s1 = 0; m_s2 = 0;
            m_req_t = -1; m_ack_t = -1; m_ntc_t = -1; m_data = '0;
        end else begin
            a       = m_s2;
            ntc_on  = (m_ntc_t >= 0) && (m_n - 1 - m_ntc_t < NC);
            idle_st = !m_wait && (m_ack_t < 0);
            done_st = !m_wait && (m_ack_t >= 0) && (m_n - 1 - m_ack_t >= SC + VC);
            if (m_wait) begin
                if (a) begin
                    m_wait = 0;
                    m_ack_t = m_n;
                    if (!ntc_on) m_ntc_t = m_n;
                end else if (TO_EN && (m_n - m_req_t >= TC)) begin
                    m_wait = 0;
                    m_terr = 1;
                end
            end else if (send && (idle_st || (done_st && !a))) begin
                m_wait  = 1;
                m_req_t = m_n;
                m_ack_t = -1;
                m_data  = {data_sel[1] ^ data_sel[0], data_sel};
                m_terr  = 0;
            end
            m_s2 = m_s1;
            m_s1 = bus.ack;
        end
        d = m_n - m_ack_t;
        e = {m_wait, m_data,
             (m_ack_t >= 0) && (d >= SC) && (d < SC + VC),
             (m_ntc_t >= 0) && (m_n - m_ntc_t < NC),
             (m_ack_t >= 0) && (d >= SC + VC),
             m_terr};
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d vectors so far", n_vec);
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        int ack_hold;
        logic [7:0] e;

        rst_n = 1'b0; top_state = 2'b01; send = 1'b0; data_sel = 2'b00; bus.ack = 1'b0;

        // Basic transfer, sends ignored mid-transfer, DONE re-accept, abort.
        tbl[0]  = mk(0, 2'b01, 0, 2'b00, 0, 8'b0_000_0000);
        tbl[1]  = mk(1, 2'b01, 0, 2'b00, 0, 8'b0_000_0000);
        tbl[2]  = mk(1, 2'b01, 1, 2'b10, 0, 8'b1_110_0000);
        tbl[3]  = mk(1, 2'b01, 0, 2'b00, 0, 8'b1_110_0000);
        tbl[4]  = mk(1, 2'b01, 1, 2'b01, 0, 8'b1_110_0000);
        tbl[5]  = mk(1, 2'b01, 0, 2'b00, 0, 8'b1_110_0000);
        tbl[6]  = mk(1, 2'b01, 0, 2'b00, 0, 8'b1_110_0000);
        tbl[7]  = mk(1, 2'b01, 0, 2'b00, 1, 8'b1_110_0000);
        tbl[8]  = mk(1, 2'b01, 0, 2'b00, 1, 8'b1_110_0000);
        tbl[9]  = mk(1, 2'b01, 0, 2'b00, 1, 8'b0_110_0100);
        tbl[10] = mk(1, 2'b01, 0, 2'b00, 1, 8'b0_110_0100);
        tbl[11] = mk(1, 2'b01, 1, 2'b01, 0, 8'b0_110_1100);
        tbl[12] = mk(1, 2'b01, 1, 2'b01, 0, 8'b0_110_1100);
        tbl[13] = mk(1, 2'b01, 0, 2'b00, 0, 8'b0_110_1100);
        tbl[14] = mk(1, 2'b01, 0, 2'b00, 0, 8'b0_110_0110);
        tbl[15] = mk(1, 2'b01, 0, 2'b00, 0, 8'b0_110_0110);
        tbl[16] = mk(1, 2'b01, 0, 2'b00, 0, 8'b0_110_0110);
        tbl[17] = mk(1, 2'b01, 0, 2'b00, 0, 8'b0_110_0110);
        tbl[18] = mk(1, 2'b01, 0, 2'b00, 0, 8'b0_110_0110);
        tbl[19] = mk(1, 2'b01, 0, 2'b00, 0, 8'b0_110_0010);
        tbl[20] = mk(1, 2'b01, 1, 2'b11, 0, 8'b1_011_0000);
        tbl[21] = mk(1, 2'b00, 0, 2'b00, 0, 8'b0_000_0000);

        for (int i = 0; i < 22; i++) begin
            rst_n = tbl[i].rst_n; top_state = tbl[i].ts; send = tbl[i].send;
            data_sel = tbl[i].ds; bus.ack = tbl[i].ack;
            tick();
            check($sformatf("vec%0d", i), 32'(outs()), 32'(tbl[i].exp));
        end
        send = 1'b0;
        top_state = 2'b01;

        // Notice length with a second ack pulse inside the window.
        pulse_send(2'b00);
        check("seqA_accept", 32'(outs()), 32'(8'b1_000_0000));
        tick(); tick();
        bus.ack = 1'b1;
        cnt = 0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (notice) cnt++;
            bus.ack = (k == 0 || k == 5 || k == 6);
        end
        check("notice_len", 32'(cnt), 32'(NC));
        check("seqA_done", 32'(all_done), 32'(1));

        // Abort during SEND, then a clean restart.
        pulse_send(2'b10);
        check("seqB_accept", 32'(outs()), 32'(8'b1_110_0000));
        tick();
        bus.ack = 1'b1;
        tick(); tick();
        bus.ack = 1'b0;
        for (int w = 0; w < 20 && !bus.valid; w++) tick();
        check("seqB_valid_seen", 32'(bus.valid), 32'(1));
        top_state = 2'b00;
        tick();
        check("abort", 32'(outs()), 32'(8'b0_000_0000));
        top_state = 2'b01;
        tick();
        check("abort_idle", 32'(outs()), 32'(8'b0_000_0000));
        pulse_send(2'b01);
        check("restart", 32'(outs()), 32'(8'b1_101_0000));

        // One-cycle reset in the middle of WAIT_ACK.
        tick(); tick();
        rst_n = 1'b0;
        tick();
        check("rst_mid_wait", 32'(outs()), 32'(8'b0_000_0000));
        rst_n = 1'b1;
        tick();
        check("post_rst_idle", 32'(outs()), 32'(8'b0_000_0000));
        pulse_send(2'b11);
        check("post_rst_send", 32'(outs()), 32'(8'b0_011_0000 | 8'b1_000_0000));

        // Ack never arrives.
        if (TO_EN) begin
            repeat (TC - 1) tick();
            check("wait_last", 32'(outs()), 32'(8'b1_011_0000));
            tick();
            check("timeout", 32'(outs()), 32'(8'b0_011_0001));
            pulse_send(2'b10);
            check("terr_clear", 32'(outs()), 32'(8'b1_110_0000));
        end else begin
            repeat (100) tick();
            check("no_timeout", 32'(outs()), 32'(8'b1_011_0000));
        end

        // DONE with the slave still holding ack: send is ignored until ack drops.
        top_state = 2'b00;
        tick();
        top_state = 2'b01;
        tick();
        pulse_send(2'b00);
        check("seqE_accept", 32'(outs()), 32'(8'b1_000_0000));
        bus.ack = 1'b1;
        repeat (12) tick();
        check("done_ack_hold", 32'({bus.request, bus.data_out, all_done}), 32'(5'b0_000_1));
        pulse_send(2'b11);
        check("send_ignored_ack", 32'({bus.request, bus.data_out, all_done}), 32'(5'b0_000_1));
        bus.ack = 1'b0;
        repeat (3) tick();
        pulse_send(2'b11);
        check("done_accept", 32'({bus.request, bus.data_out, all_done}), 32'(5'b1_011_0));

        // Randomized traffic against the reference model.
        m_n = 0;
        ack_hold = 0;
        for (int i = 0; i < 3000; i++) begin
            rst_n     = (i == 0) ? 1'b0 : ($urandom_range(0, 299) != 0);
            top_state = ($urandom_range(0, 149) == 0) ? 2'($urandom_range(0, 3)) : 2'b01;
            send      = ($urandom_range(0, 4) == 0);
            data_sel  = 2'($urandom);
            if (ack_hold > 0) begin
                bus.ack = 1'b1;
                ack_hold--;
            end else if (bus.request && $urandom_range(0, 7) == 0) begin
                bus.ack = 1'b1;
                ack_hold = $urandom_range(0, 5);
            end else begin
                bus.ack = ($urandom_range(0, 59) == 0);
            end
            model_step(e);
            tick();
            check("rand", 32'(outs()), 32'(e));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
